// File: rtl/fft_pkg.sv
// Shared FFT helpers: address width and bit-reversal used by both the
// input-side scrambler and the output reorder buffer.
package fft_pkg;

    localparam int unsigned FFT_SAMPLES = 4;
    localparam int unsigned FFT_AW      = $clog2(FFT_SAMPLES);
    localparam int unsigned FFT_MAX_AW  = 16;

    function automatic int unsigned addr_width(input int unsigned samples);
        return $clog2(samples);
    endfunction

    // Reverses the low aw bits of k; bits at and above aw are returned as zero.
    function automatic logic [FFT_MAX_AW-1:0] bitrev(input logic [FFT_MAX_AW-1:0] k,
                                                     input int unsigned aw);
        logic [FFT_MAX_AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FFT_MAX_AW; i++) begin
            if (i < aw) begin
                r[i] = k[aw-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: synchronous write port, combinational read port.
module fft_reorder_bank #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed FFT output frames into natural order using two
// ping-pong banks; writes scatter to bitrev addresses, reads run linearly.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int unsigned SAMPLES = 4,
    parameter int unsigned WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_err
);

    localparam int unsigned AW = addr_width(SAMPLES);
    localparam logic [AW-1:0] CNT_MAX = AW'(SAMPLES - 1);

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          frame_err_q, frame_err_d;

    logic             in_fire;
    logic             out_fire;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] bank_rdata [2];

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = bank_rdata[rd_bank_q];
    assign out_last  = out_valid && (rd_cnt_q == CNT_MAX);
    assign frame_err = frame_err_q;
    assign wr_addr   = AW'(bitrev(FFT_MAX_AW'(wr_cnt_q), AW));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank #(
            .WIDTH (WIDTH),
            .DEPTH (SAMPLES),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .we_i    (in_fire && (wr_bank_q == 1'(b))),
            .waddr_i (wr_addr),
            .wdata_i (in_data),
            .raddr_i (rd_cnt_q),
            .rdata_o (bank_rdata[b])
        );
    end

    // Write completion and read drain always target different banks, so both
    // full-flag updates can be applied in the same cycle without conflict.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        frame_err_d = in_fire && (in_last != (wr_cnt_q == CNT_MAX));

        if (in_fire) begin
            if (wr_cnt_q == CNT_MAX) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end

        if (out_fire) begin
            if (rd_cnt_q == CNT_MAX) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 SHALL have parameter SAMPLES, default 4, meaning the frame length in samples; must be a power of two and at least 4.
REQ-002 SHALL have parameter WIDTH, default 2, meaning the bit width of one sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_data (input, WIDTH), in_valid (input, 1) and in_ready (output, 1): the sample stream arriving in bit-reversed index order.
REQ-006 SHALL have port in_last, input, 1 bit: upstream end-of-frame marker, used only for checking.
REQ-007 SHALL have ports out_data (output, WIDTH), out_valid (output, 1) and out_ready (input, 1): the sample stream leaving in natural index order.
REQ-008 SHALL have port out_last, output, 1 bit: high on sample SAMPLES-1 of each output frame.
REQ-009 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on an in_last mismatch.

Function
REQ-010 SHALL treat a transfer as occurring only on a cycle where valid and ready are both high, on each side independently.
REQ-011 SHALL hold two banks (ping-pong), each storing SAMPLES words of WIDTH bits.
REQ-012 SHALL keep per-bank full flags, a write-bank pointer wr_bank, a read-bank pointer rd_bank, a write counter wr_cnt and a read counter rd_cnt; each counter is clog2(SAMPLES) bits.
REQ-013 SHALL write the k-th accepted input sample of a frame (k = wr_cnt) to address bitrev(k) of bank wr_bank; bitrev reverses the clog2(SAMPLES) address bits.
REQ-014 SHALL increment wr_cnt on each input transfer; on the transfer where wr_cnt = SAMPLES-1 it SHALL wrap wr_cnt to 0, set full[wr_bank] and toggle wr_bank.
REQ-015 SHALL drive in_ready = !full[wr_bank], using registered flags only; in_ready SHALL NOT depend combinationally on out_ready.
REQ-016 SHALL drive out_valid = full[rd_bank] and out_data = bank[rd_bank][rd_cnt], combinationally from registers.
REQ-017 SHALL drive out_last = out_valid && (rd_cnt == SAMPLES-1).
REQ-018 SHALL increment rd_cnt on each output transfer; on the transfer where rd_cnt = SAMPLES-1 it SHALL wrap rd_cnt to 0, clear full[rd_bank] and toggle rd_bank.
REQ-019 SHALL have a latency of exactly one cycle: out_valid rises in the cycle after the final input transfer of a frame.
REQ-020 SHALL sustain one sample per cycle in and one per cycle out when out_ready is held high.
REQ-021 SHALL, with both banks full, hold in_ready low; it SHALL rise in the cycle after the draining bank's last output transfer.
REQ-022 SHALL allow a frame completion on the write side and a frame drain on the read side in the same cycle; they target different banks and both updates SHALL apply.
REQ-023 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-024 SHALL pulse frame_err for one cycle on an input transfer where in_last != (wr_cnt == SAMPLES-1); framing SHALL continue to follow wr_cnt only.

Reset
REQ-025 SHALL, while rst_n is low, immediately clear wr_cnt, rd_cnt, wr_bank, rd_bank, both full flags and frame_err, regardless of clk.
REQ-026 SHALL, during reset, drive out_valid=0, out_last=0 and in_ready=1 once rst_n is released.
REQ-027 SHALL not reset bank storage; out_data is don't-care while out_valid is 0.
REQ-028 SHALL, on reset mid-frame, discard all partial and buffered frames; the next input sample is k=0.

Structure
REQ-029 SHALL take the bitrev function and a width localparam (clog2 of SAMPLES) from shared package fft_pkg; the input-side scrambler SHALL use the same package.
REQ-030 SHALL implement each bank as sub-module fft_reorder_bank (write-enable, write address, write data, combinational read address and read data), instantiated twice.

Verification
REQ-031 SHALL cover: with SAMPLES=8, WIDTH=8, input data 0,4,2,6,1,5,3,7 and out_ready=1 -> output 0..7 in order, out_last on 7, out_valid first high one cycle after the 8th input transfer.
REQ-032 SHALL cover: four back-to-back frames with all valids and readies high -> no bubbles, in_ready always 1, 32 outputs with correct order.
REQ-033 SHALL cover: out_ready=0 while two frames are sent -> in_ready drops after the 16th transfer; raising out_ready -> in_ready returns one cycle after the 8th output transfer.
REQ-034 SHALL cover: in_last asserted on the 5th sample -> frame_err pulses once, and frame output is unchanged.
REQ-035 SHALL cover: rst_n asserted after 3 input samples -> outputs clear immediately; a following clean frame reorders correctly.
REQ-036 SHALL cover: random valid/ready gaps over 100 frames -> the scoreboard matches the natural-order model.
